mux4to1_8bits: RTL and testbench

Registered 4-to-1 selector over three 8-bit data inputs plus a constant-zero fourth leg. The 2-bit `selector` picks `in1`, `in2` or `in3`. Code `2'b11` drives a defined all-zero word and raises an invalid-select flag. The block sits in datapaths that need a clean, clocked steering point, and its output never carries X.

---
 rtl/mux4to1_pkg.sv | 12 +
 rtl/mux4to1_core.sv | 30 +++
 rtl/mux4to1_8bits.sv | 43 ++++
 tb/tb_mux4to1_8bits.sv | 126 ++++++++++++
 4 files changed

// File: rtl/mux4to1_pkg.sv
// Shared definitions for the registered 4-to-1 selector: select encodings
// and the default data width.
package mux4to1_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] SEL_IN1  = 2'b00;
    localparam logic [1:0] SEL_IN2  = 2'b01;
    localparam logic [1:0] SEL_IN3  = 2'b10;
    localparam logic [1:0] SEL_RSVD = 2'b11;

endpackage

// File: rtl/mux4to1_core.sv
// Purely combinational selector: picks one of three data words, or a defined
// zero word plus an invalid flag for the reserved code.
module mux4to1_core
    import mux4to1_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [1:0]       selector,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    output logic [WIDTH-1:0] next_data,
    output logic             next_invalid
);

    // Anything outside the three legal codes falls to the zero leg, so the
    // reserved code never propagates an undefined word downstream.
    always_comb begin
        next_data = '0;
        case (selector)
            SEL_IN1: next_data = in1;
            SEL_IN2: next_data = in2;
            SEL_IN3: next_data = in3;
            default: next_data = '0;
        endcase
    end

    assign next_invalid = (selector == SEL_RSVD);

endmodule

// File: rtl/mux4to1_8bits.sv
// Registered 4-to-1 steering point: the combinational core followed by an
// output register with asynchronous active-high reset.
module mux4to1_8bits
    import mux4to1_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       selector,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    output logic [WIDTH-1:0] outData,
    output logic             selInvalid
);

    logic [WIDTH-1:0] nextData;
    logic             nextInvalid;

    mux4to1_core #(
        .WIDTH(WIDTH)
    ) core (
        .selector    (selector),
        .in1         (in1),
        .in2         (in2),
        .in3         (in3),
        .next_data   (nextData),
        .next_invalid(nextInvalid)
    );

    // Reset clears the register at once, discarding whatever sample was in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outData    <= '0;
            selInvalid <= 1'b0;
        end else begin
            outData    <= nextData;
            selInvalid <= nextInvalid;
        end
    end

endmodule

// File: tb/tb_mux4to1_8bits.sv
// Scoreboard bench for mux4to1_8bits: directed vectors push expected words,
// a monitor pops and compares one cycle later.
module tb_mux4to1_8bits;

    typedef struct packed {
        logic [7:0] data;
        logic       inv;
    } expT;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] selector = 2'b00;
    logic [7:0] in1 = 8'd5;
    logic [7:0] in2 = 8'd10;
    logic [7:0] in3 = 8'd15;
    logic [7:0] outData;
    logic       selInvalid;

    expT   expQueue[$];
    string nameQueue[$];
    int    checkCount = 0;
    int    failCount  = 0;

    mux4to1_8bits #(
        .WIDTH(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .selector  (selector),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .outData   (outData),
        .selInvalid(selInvalid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] expData, input logic expInv);
        checkCount++;
        if (outData !== expData || selInvalid !== expInv) begin
            failCount++;
            $display("[TB] FAIL %s: got outData=%02h selInvalid=%b, expected outData=%02h selInvalid=%b",
                     name, outData, selInvalid, expData, expInv);
        end
    endtask

    // Drives one vector on the falling edge and records what the next rising edge must produce.
    task automatic applyStimulus(input string name, input logic rstVal, input logic [1:0] sel,
                                 input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                                 input logic [7:0] expData, input logic expInv);
        expT e;
        @(negedge clk);
        reset    = rstVal;
        selector = sel;
        in1      = a;
        in2      = b;
        in3      = c;
        e.data   = expData;
        e.inv    = expInv;
        expQueue.push_back(e);
        nameQueue.push_back(name);
    endtask

    initial begin : monitor
        expT   e;
        string n;
        forever begin
            @(posedge clk);
            #1;
            if (expQueue.size() > 0) begin
                e = expQueue.pop_front();
                n = nameQueue.pop_front();
                checkOutput(n, e.data, e.inv);
            end
        end
    end

    initial begin : watchdog
        #20000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 20000 time units");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        #1 reset = 1'b1;
        #1 checkOutput("reset_async", 8'h00, 1'b0);

        applyStimulus("reset_held_rsvd", 1'b1, 2'b11, 8'd5, 8'd10, 8'd15, 8'h00, 1'b0);
        applyStimulus("reset_held_in3",  1'b1, 2'b10, 8'd5, 8'd10, 8'hFF, 8'h00, 1'b0);

        applyStimulus("sel_in1",      1'b0, 2'b00, 8'd5, 8'd10, 8'd15, 8'd5,  1'b0);
        applyStimulus("sel_in2",      1'b0, 2'b01, 8'd5, 8'd10, 8'd15, 8'd10, 1'b0);
        applyStimulus("sel_in3",      1'b0, 2'b10, 8'd5, 8'd10, 8'd15, 8'd15, 1'b0);
        applyStimulus("sel_rsvd",     1'b0, 2'b11, 8'd5, 8'd10, 8'd15, 8'h00, 1'b1);
        applyStimulus("sel_back_in1", 1'b0, 2'b00, 8'd5, 8'd10, 8'd15, 8'd5,  1'b0);

        // in1 changes mid-cycle; the registered output must still show the old word.
        applyStimulus("hold_then_200", 1'b0, 2'b00, 8'd200, 8'd10, 8'd15, 8'd200, 1'b0);
        #1 checkOutput("hold_mid_cycle", 8'd5, 1'b0);

        applyStimulus("in3_all_ones", 1'b0, 2'b10, 8'd200, 8'd10, 8'hFF, 8'hFF, 1'b0);
        @(posedge clk);
        #3 reset = 1'b1;
        #1 checkOutput("reset_mid_stream", 8'h00, 1'b0);
        applyStimulus("reset_mid_held",  1'b1, 2'b10, 8'd200, 8'd10, 8'hFF, 8'h00, 1'b0);
        applyStimulus("reset_release",   1'b0, 2'b10, 8'd200, 8'd10, 8'hFF, 8'hFF, 1'b0);

        applyStimulus("in1_a5",      1'b0, 2'b00, 8'hA5, 8'h5A, 8'h3C, 8'hA5, 1'b0);
        applyStimulus("in2_5a",      1'b0, 2'b01, 8'hA5, 8'h5A, 8'h3C, 8'h5A, 1'b0);
        applyStimulus("rsvd_again",  1'b0, 2'b11, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b1);
        applyStimulus("in3_3c",      1'b0, 2'b10, 8'hA5, 8'h5A, 8'h3C, 8'h3C, 1'b0);
        applyStimulus("in2_zero",    1'b0, 2'b01, 8'hFF, 8'h00, 8'hFF, 8'h00, 1'b0);

        repeat (3) @(negedge clk);
        checkCount++;
        if (expQueue.size() != 0) begin
            failCount++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", expQueue.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
